// File: rtl/strobe_nco_divider.sv
// Multi-channel strobe rate divider: per-channel phase-accumulator or integer-modulus division of i_stb.
// Optional macro STROBE_NCO_PHASE_OUT_EN exposes each channel's registered accumulator on o_phase.
module strobe_nco_divider #(
  parameter int ACC_WIDTH    = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int CHAN_BITS    = 1,
  parameter int DEFAULT_STEP = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_stb,
  input  logic                              i_cfg_stb,
  input  logic [CHAN_BITS-1:0]              i_cfg_chan,
  input  logic [ACC_WIDTH-1:0]              i_cfg_step,
  input  logic                              i_cfg_mode,
  output logic [NUM_CHANNELS-1:0]           o_stb,
  output logic                              o_cfg_ack,
  output logic                              o_cfg_err
`ifdef STROBE_NCO_PHASE_OUT_EN
  ,
  output logic [NUM_CHANNELS*ACC_WIDTH-1:0] o_phase
`endif
);

  localparam logic [ACC_WIDTH-1:0] ONE      = ACC_WIDTH'(1);
  localparam logic [ACC_WIDTH-1:0] STEP_RST = ACC_WIDTH'(DEFAULT_STEP);
  localparam logic [CHAN_BITS:0]   NUM_CH   = (CHAN_BITS+1)'(NUM_CHANNELS);

  // Returns {carry, sum} of the phase accumulator update.
  function automatic logic [ACC_WIDTH:0] accum_add(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [ACC_WIDTH-1:0] step);
    return {1'b0, acc} + {1'b0, step};
  endfunction

  // Returns {wrap, next}; a zero modulus parks the counter.
  function automatic logic [ACC_WIDTH:0] modulo_next(input logic [ACC_WIDTH-1:0] acc,
                                                     input logic [ACC_WIDTH-1:0] step);
    if (step == '0)
      return {1'b0, acc};
    else if (acc >= step - ONE)
      return {1'b1, {ACC_WIDTH{1'b0}}};
    else
      return {1'b0, acc + ONE};
  endfunction

  logic chan_ok;
  logic cfg_ok;

  assign chan_ok = ({1'b0, i_cfg_chan} < NUM_CH);
  assign cfg_ok  = i_cfg_stb && chan_ok;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
    logic [ACC_WIDTH-1:0] acc_p0;
    logic [ACC_WIDTH-1:0] step_p0;
    logic                 mode_p0;
    logic                 stb_p0;
    logic                 wr;
    logic [ACC_WIDTH:0]   nxt;

    assign wr  = cfg_ok && (i_cfg_chan == CHAN_BITS'(k));
    assign nxt = mode_p0 ? modulo_next(acc_p0, step_p0) : accum_add(acc_p0, step_p0);

    // Stage p0: channel state and its output strobe; a write wins over i_stb.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        acc_p0  <= '0;
        step_p0 <= STEP_RST;
        mode_p0 <= 1'b0;
        stb_p0  <= 1'b0;
      end else if (wr) begin
        acc_p0  <= '0;
        step_p0 <= i_cfg_step;
        mode_p0 <= i_cfg_mode;
        stb_p0  <= 1'b0;
      end else if (i_stb) begin
        acc_p0  <= nxt[ACC_WIDTH-1:0];
        stb_p0  <= nxt[ACC_WIDTH];
      end else begin
        stb_p0  <= 1'b0;
      end
    end

    assign o_stb[k] = stb_p0;
`ifdef STROBE_NCO_PHASE_OUT_EN
    assign o_phase[k*ACC_WIDTH +: ACC_WIDTH] = acc_p0;
`endif
  end

  logic ack_p0;
  logic err_p0;

  // Stage p0: write acknowledge, flagged as an error for out-of-range channels.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_p0 <= 1'b0;
      err_p0 <= 1'b0;
    end else begin
      ack_p0 <= i_cfg_stb;
      err_p0 <= i_cfg_stb && !chan_ok;
    end
  end

  assign o_cfg_ack = ack_p0;
  assign o_cfg_err = err_p0;

endmodule

// File: tb/tb_strobe_nco_divider.sv
// Bench for strobe_nco_divider: pulse-count reference model checked every cycle plus literal directed checks.
module tb_strobe_nco_divider;

  localparam int AW  = 4;
  localparam int NCH = 2;
  localparam int MOD = 16;

  logic                clk = 1'b0;
  logic                i_rst = 1'b1;
  logic                i_stb = 1'b0;
  logic                i_cfg_stb = 1'b0;
  logic [1:0]          i_cfg_chan = '0;
  logic [AW-1:0]       i_cfg_step = '0;
  logic                i_cfg_mode = 1'b0;
  logic [NCH-1:0]      o_stb;
  logic                o_cfg_ack;
  logic                o_cfg_err;
`ifdef STROBE_NCO_PHASE_OUT_EN
  logic [NCH*AW-1:0]   o_phase;
`endif

  int total = 0;
  int bad   = 0;

  strobe_nco_divider #(
    .ACC_WIDTH(AW), .NUM_CHANNELS(NCH), .CHAN_BITS(2), .DEFAULT_STEP(1)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_stb(i_stb), .i_cfg_stb(i_cfg_stb),
    .i_cfg_chan(i_cfg_chan), .i_cfg_step(i_cfg_step), .i_cfg_mode(i_cfg_mode),
    .o_stb(o_stb), .o_cfg_ack(o_cfg_ack), .o_cfg_err(o_cfg_err)
`ifdef STROBE_NCO_PHASE_OUT_EN
    , .o_phase(o_phase)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: a channel is described by the number of i_stb pulses n since its last write.
  // ACCUM: the output strobes whenever floor(n*step/2^AW) increases; acc = n*step mod 2^AW.
  // MODULO: pulse number n strobes when n is a multiple of step; acc = n mod step.
  function automatic bit f_stb(input int n, input int s, input bit md);
    if (!md) return (((n + 1) * s) / MOD) != ((n * s) / MOD);
    return (s != 0) && (((n + 1) % s) == 0);
  endfunction

  function automatic int f_next(input int n, input int s, input bit md);
    if (md && s == 0) return n;
    return n + 1;
  endfunction

  function automatic int f_acc(input int n, input int s, input bit md);
    if (!md) return (n * s) % MOD;
    if (s == 0) return 0;
    return n % s;
  endfunction

  int             mn[NCH] = '{0, 0};
  int             ms[NCH] = '{1, 1};
  bit             mm[NCH] = '{0, 0};
  logic [NCH-1:0] e_stb = '0;
  logic           e_ack = 1'b0;
  logic           e_err = 1'b0;
  logic [AW-1:0]  e_acc[NCH] = '{4'd0, 4'd0};

  always @(posedge clk) begin
    if (i_rst) begin
      e_stb <= '0;
      e_ack <= 1'b0;
      e_err <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        mn[k] <= 0; ms[k] <= 1; mm[k] <= 1'b0; e_acc[k] <= '0;
      end
    end else begin
      e_ack <= i_cfg_stb;
      e_err <= i_cfg_stb && (int'(i_cfg_chan) >= NCH);
      for (int k = 0; k < NCH; k++) begin
        if (i_cfg_stb && int'(i_cfg_chan) == k) begin
          mn[k] <= 0; ms[k] <= int'(i_cfg_step); mm[k] <= i_cfg_mode;
          e_stb[k] <= 1'b0; e_acc[k] <= '0;
        end else if (i_stb) begin
          e_stb[k] <= f_stb(mn[k], ms[k], mm[k]);
          mn[k]    <= f_next(mn[k], ms[k], mm[k]);
          e_acc[k] <= AW'(f_acc(f_next(mn[k], ms[k], mm[k]), ms[k], mm[k]));
        end else begin
          e_stb[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_stb", o_stb, e_stb);
    check("model_ack", o_cfg_ack, e_ack);
    check("model_err", o_cfg_err, e_err);
`ifdef STROBE_NCO_PHASE_OUT_EN
    check("model_phase", o_phase, {e_acc[1], e_acc[0]});
`endif
  end

  task automatic drive(input bit stb, input bit cs, input logic [1:0] ch,
                       input logic [AW-1:0] st, input bit md, input bit r);
    i_stb = stb; i_cfg_stb = cs; i_cfg_chan = ch; i_cfg_step = st; i_cfg_mode = md; i_rst = r;
    @(posedge clk);
    #1;
    i_stb = 1'b0; i_cfg_stb = 1'b0; i_cfg_chan = '0; i_cfg_step = '0; i_cfg_mode = 1'b0; i_rst = 1'b0;
  endtask

  task automatic pulse();
    drive(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
  endtask

  logic [10:0] pat3;
  int          accseq[11];

  initial begin
    pat3   = 11'b100_0010_0000;
    accseq = '{3, 6, 9, 12, 15, 2, 5, 8, 11, 14, 1};

    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'd0, 4'd7, 1'b1, 1'b1);
    check("reset_stb", o_stb, 2'b00);
    check("reset_ack", o_cfg_ack, 1'b0);
    check("reset_err", o_cfg_err, 1'b0);

    // ACCUM integer ratio, step 4
    drive(1'b0, 1'b1, 2'd0, 4'd4, 1'b0, 1'b0);
    check("cfg_ack", o_cfg_ack, 1'b1);
    check("cfg_err", o_cfg_err, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      pulse();
      check("accum4_stb", o_stb[0], (i % 4) == 0);
    end

    // ACCUM fractional, step 3
    drive(1'b0, 1'b1, 2'd0, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      pulse();
      check("accum3_stb", o_stb[0], pat3[i]);
`ifdef STROBE_NCO_PHASE_OUT_EN
      check("accum3_acc", o_phase[3:0], 4'(accseq[i]));
`endif
    end

    // ch0 ACCUM 8 alongside ch1 MODULO 5
    drive(1'b0, 1'b1, 2'd0, 4'd8, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 4'd5, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      pulse();
      check("mix_ch0", o_stb[0], (i % 2) == 0);
      check("mix_ch1", o_stb[1], (i % 5) == 0);
    end

    // write collides with the carrying i_stb on ch0
    pulse();
    check("pre_collide", o_stb[0], 1'b0);
    drive(1'b1, 1'b1, 2'd0, 4'd2, 1'b1, 1'b0);
    check("collide_stb", o_stb[0], 1'b0);
    check("collide_ack", o_cfg_ack, 1'b1);
    pulse();
    check("collide_p1", o_stb[0], 1'b0);
    pulse();
    check("collide_p2", o_stb[0], 1'b1);

    // invalid channel, idle and with i_stb
    drive(1'b0, 1'b1, 2'd3, 4'd7, 1'b1, 1'b0);
    check("inv_ack", o_cfg_ack, 1'b1);
    check("inv_err", o_cfg_err, 1'b1);
    drive(1'b1, 1'b1, 2'd2, 4'd0, 1'b0, 1'b0);
    check("inv2_err", o_cfg_err, 1'b1);
    for (int i = 0; i < 6; i++) pulse();

    // ch0 ACCUM 15, ch1 MODULO 1 with gapped strobes
    drive(1'b0, 1'b1, 2'd0, 4'd15, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive((i % 3) != 0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0);
      check("mod1_stb", o_stb[1], (i % 3) != 0);
    end

    // zero step never strobes in either mode
    drive(1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      pulse();
      check("zero_stb", o_stb, 2'b00);
    end

    // ACCUM 9 then MODULO 3 ahead of a mid-run reset
    drive(1'b0, 1'b1, 2'd0, 4'd9, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'd1, 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) pulse();
    drive(1'b1, 1'b1, 2'd1, 4'd5, 1'b1, 1'b1);
    check("midrst_stb", o_stb, 2'b00);
    check("midrst_ack", o_cfg_ack, 1'b0);
    check("midrst_err", o_cfg_err, 1'b0);
`ifdef STROBE_NCO_PHASE_OUT_EN
    check("midrst_phase", o_phase, 8'h00);
`endif
    for (int i = 1; i <= 16; i++) begin
      pulse();
      check("dflt_ch0", o_stb[0], i == 16);
      check("dflt_ch1", o_stb[1], i == 16);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
